// File: rtl/lut_eval_seq.sv
// lut_eval_seq: sequential truth-table evaluator.
//  - A live truth table of 2^N_IN bits maps each input vector to one result bit.
//    Row idx = in_vec selects table bit 2^N_IN-1-idx, so the table reads MSB-first
//    in row order.
//  - The table is reloadable through a serial, MSB-first port. Bits are gathered in
//    a shadow register and committed atomically once the final bit arrives.
//  - Results are queued in a 2-entry FIFO with valid/ready handshakes.
// Optional feature, enabled by defining LUT_EVAL_SEQ_PARITY_EN:
//   each load carries one trailing even-parity bit. A load whose parity does not
//   check keeps the old table and raises cfg_err.
module lut_eval_seq #(
   parameter int unsigned N_IN    = 3,
   parameter logic [63:0] TT_INIT = 64'h70
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_start,
   input  logic            cfg_bit_valid,
   input  logic            cfg_bit,
   output logic            cfg_busy,
   output logic            cfg_done,
   output logic            cfg_err,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N_IN-1:0] in_vec,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_bit
);

   localparam int unsigned TT_W = 1 << N_IN;
`ifdef LUT_EVAL_SEQ_PARITY_EN
   localparam int unsigned LOAD_BITS = TT_W + 1;
`else
   localparam int unsigned LOAD_BITS = TT_W;
`endif
   localparam int unsigned    CNT_W    = $clog2(LOAD_BITS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LOAD_BITS - 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [TT_W-1:0]   shadow_q, shadow_d;
   logic [TT_W-1:0]   table_q, table_d;
   logic              done_q, done_d;
`ifdef LUT_EVAL_SEQ_PARITY_EN
   logic              err_q, err_d;
`endif

   logic [1:0]        mem_q, mem_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic [1:0]        cnt_q, cnt_d;

   logic [N_IN-1:0]   row;
   logic              lut_res;
   logic              push;
   logic              pop;
   logic              fifo_valid;

   // Serial-load FSM: next state, bit counter, shadow shift and table commit
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shadow_d  = shadow_q;
      table_d   = table_q;
      done_d    = 1'b0;
`ifdef LUT_EVAL_SEQ_PARITY_EN
      err_d     = err_q;
`endif
      if (cfg_start) begin
         // Entering or restarting a load always begins from an empty shadow.
         state_d   = ST_LOAD;
         bit_cnt_d = '0;
         shadow_d  = '0;
`ifdef LUT_EVAL_SEQ_PARITY_EN
         err_d     = 1'b0;
`endif
      end else if ((state_q == ST_LOAD) && cfg_bit_valid) begin
         if (bit_cnt_q == LAST_IDX) begin
            state_d   = ST_RUN;
            bit_cnt_d = '0;
`ifdef LUT_EVAL_SEQ_PARITY_EN
            // Final bit is the parity bit; the shadow already holds the full table.
            if (((^shadow_q) ^ cfg_bit) == 1'b0) begin
               table_d = shadow_q;
               done_d  = 1'b1;
            end else begin
               err_d   = 1'b1;
            end
`else
            table_d = {shadow_q[TT_W-2:0], cfg_bit};
            done_d  = 1'b1;
`endif
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shadow_d  = {shadow_q[TT_W-2:0], cfg_bit};
         end
      end
   end

   // Result FIFO: accept, evaluate against the live table, and dequeue
   always_comb begin
      fifo_valid = (cnt_q != 2'd0);
      in_ready   = (state_q == ST_RUN) && (cnt_q < 2'd2) && !cfg_start;
      push       = in_valid && in_ready;
      pop        = fifo_valid && out_ready;
      // Row idx lives at bit 2^N_IN-1-idx, which is the bitwise complement of idx.
      row        = ~in_vec;
      lut_res    = table_q[row];
      mem_d      = mem_q;
      if (push) begin
         mem_d[wr_q] = lut_res;
      end
      wr_d = wr_q ^ push;
      rd_d = rd_q ^ pop;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // State, table and FIFO registers; reset restores the power-on table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         bit_cnt_q <= '0;
         shadow_q  <= '0;
         table_q   <= TT_INIT[TT_W-1:0];
         done_q    <= 1'b0;
`ifdef LUT_EVAL_SEQ_PARITY_EN
         err_q     <= 1'b0;
`endif
         mem_q     <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shadow_q  <= shadow_d;
         table_q   <= table_d;
         done_q    <= done_d;
`ifdef LUT_EVAL_SEQ_PARITY_EN
         err_q     <= err_d;
`endif
         mem_q     <= mem_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
      end
   end

   assign cfg_busy  = (state_q == ST_LOAD);
   assign cfg_done  = done_q;
`ifdef LUT_EVAL_SEQ_PARITY_EN
   assign cfg_err   = err_q;
`else
   assign cfg_err   = 1'b0;
`endif
   assign out_valid = fifo_valid;
   // Gated so the output reads 0 whenever the queue is empty.
   assign out_bit   = fifo_valid & mem_q[rd_q];

endmodule

// File: tb/tb_lut_eval_seq.sv
// Self-checking bench for lut_eval_seq (N_IN=3). A behavioural model holds the
// table as a plain bit vector, loads as a list of received bits, and pending
// results as a queue; every cycle the DUT outputs are compared against it.
module tb_lut_eval_seq;

   localparam int TT_W = 8;
`ifdef LUT_EVAL_SEQ_PARITY_EN
   localparam int LOAD_BITS = TT_W + 1;
`else
   localparam int LOAD_BITS = TT_W;
`endif

   logic       clk;
   logic       rst_n;
   logic       cfg_start, cfg_bit_valid, cfg_bit;
   logic       cfg_busy, cfg_done, cfg_err;
   logic       in_valid, in_ready;
   logic [2:0] in_vec;
   logic       out_valid, out_ready, out_bit;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model
   logic [63:0] m_tt;
   bit          m_busy, m_done, m_err;
   bit          bits[$];
   bit          q[$];
   bit          obs[$];
   int          done_seen;

   lut_eval_seq #(.N_IN(3), .TT_INIT(64'h70)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle: drive, compare against model, advance model, step clock.
   task automatic cycle(input bit iv, input logic [2:0] vec, input bit ordy,
                        input bit cs, input bit cbv, input bit cb);
      bit          exp_ready, exp_ov, exp_ob, acc, ok;
      int          ones;
      logic [63:0] nt;
      in_valid = iv; in_vec = vec; out_ready = ordy;
      cfg_start = cs; cfg_bit_valid = cbv; cfg_bit = cb;
      #1;
      exp_ready = !m_busy && (q.size() < 2) && !cs;
      exp_ov    = (q.size() != 0);
      exp_ob    = (q.size() != 0) ? q[0] : 1'b0;
      n_cmp++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL in_ready: got %b expected %b t=%0t", in_ready, exp_ready, $time); end
      n_cmp++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL out_valid: got %b expected %b t=%0t", out_valid, exp_ov, $time); end
      n_cmp++; if (out_bit !== exp_ob) begin n_fail++; $display("FAIL out_bit: got %b expected %b t=%0t", out_bit, exp_ob, $time); end
      n_cmp++; if (cfg_busy !== m_busy) begin n_fail++; $display("FAIL cfg_busy: got %b expected %b t=%0t", cfg_busy, m_busy, $time); end
      n_cmp++; if (cfg_done !== m_done) begin n_fail++; $display("FAIL cfg_done: got %b expected %b t=%0t", cfg_done, m_done, $time); end
      n_cmp++; if (cfg_err !== m_err) begin n_fail++; $display("FAIL cfg_err: got %b expected %b t=%0t", cfg_err, m_err, $time); end
      if (out_valid === 1'b1 && ordy) obs.push_back(out_bit);
      if (cfg_done === 1'b1) done_seen++;
      // model update for this clock edge
      acc = exp_ready && iv;
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(m_tt[TT_W-1-int'(vec)]);
      m_done = 1'b0;
      if (cs) begin
         m_busy = 1'b1; m_err = 1'b0; bits.delete();
      end else if (m_busy && cbv) begin
         bits.push_back(cb);
         if (bits.size() == LOAD_BITS) begin
            nt = '0; ones = 0;
            for (int i = 0; i < TT_W; i++) begin
               nt[TT_W-1-i] = bits[i];
               ones += int'(bits[i]);
            end
            ok = 1'b1;
`ifdef LUT_EVAL_SEQ_PARITY_EN
            ok = ((ones + int'(bits[TT_W])) % 2) == 0;
`endif
            if (ok) begin m_tt = nt; m_done = 1'b1; end
            else m_err = 1'b1;
            m_busy = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_tt = 64'h70; m_busy = 0; m_done = 0; m_err = 0;
      bits.delete(); q.delete();
   endtask

   task automatic do_reset();
      in_valid = 0; in_vec = 0; out_ready = 0;
      cfg_start = 0; cfg_bit_valid = 0; cfg_bit = 0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit: got %b expected 0", out_bit); end
      n_cmp++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_busy: got %b expected 0", cfg_busy); end
      n_cmp++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_done: got %b expected 0", cfg_done); end
      n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   // Offer vectors 0..7 with out_ready high; compare consumed results to pat.
   task automatic eval_all(input logic [7:0] pat, input string name);
      obs.delete();
      for (int v = 0; v < 8; v++) cycle(1, 3'(v), 1, 0, 0, 0);
      repeat (3) cycle(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (obs.size() != 8) begin
         n_fail++; $display("FAIL %s_count: got %0d results expected 8", name, obs.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== pat[7-i]) begin n_fail++; $display("FAIL %s_row%0d: got %b expected %b", name, i, obs[i], pat[7-i]); end
         end
      end
   endtask

   task automatic load_table(input logic [63:0] tt, input bit par, input bit gaps);
      done_seen = 0;
      cycle(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < TT_W; i++) begin
         if (gaps && ((i % 2 == 0) || $urandom_range(0, 1) == 1))
            cycle(0, 0, 1, 0, 0, 1'($urandom_range(0, 1)));
         cycle(0, 0, 1, 0, 1, tt[TT_W-1-i]);
      end
`ifdef LUT_EVAL_SEQ_PARITY_EN
      cycle(0, 0, 1, 0, 1, par);
`endif
      repeat (2) cycle(0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_default_table();
      eval_all(8'h70, "default");
   endtask

   task automatic test_backpressure();
      bit exp3[3];
      obs.delete();
      cycle(1, 3'd1, 0, 0, 0, 0);
      cycle(1, 3'd2, 0, 0, 0, 0);
      in_valid = 1; in_vec = 3'd5; out_ready = 0;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
      cycle(1, 3'd5, 0, 0, 0, 0);
      cycle(1, 3'd5, 0, 0, 0, 0);
      cycle(1, 3'd5, 1, 0, 0, 0);
      cycle(1, 3'd5, 1, 0, 0, 0);
      repeat (3) cycle(0, 0, 1, 0, 0, 0);
      exp3[0] = 1; exp3[1] = 1; exp3[2] = 0;
      n_cmp++;
      if (obs.size() != 3) begin
         n_fail++; $display("FAIL bp_count: got %0d results expected 3", obs.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs[i] !== exp3[i]) begin n_fail++; $display("FAIL bp_order%0d: got %b expected %b", i, obs[i], exp3[i]); end
         end
      end
   endtask

   task automatic test_load_96();
      load_table(64'h96, 1'b0, 1'b1);
      n_cmp++; if (done_seen != 1) begin n_fail++; $display("FAIL load96_done_pulses: got %0d expected 1", done_seen); end
      eval_all(8'h96, "load96");
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] t;
      t = 8'h96;
      cycle(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 1, t[7-i]);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL midload_busy: got %b expected 0", cfg_busy); end
      do_reset();
      eval_all(8'h70, "midload");
   endtask

   task automatic test_start_priority();
      cycle(1, 3'd1, 1, 1, 0, 0);
      in_valid = 0; cfg_start = 0;
      #1;
      n_cmp++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy: got %b expected 1", cfg_busy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL prio_accept: got out_valid %b expected 0", out_valid); end
      load_table(64'h70, 1'b1, 1'b0);
   endtask

`ifdef LUT_EVAL_SEQ_PARITY_EN
   task automatic test_parity();
      load_table(64'h96, 1'b0, 1'b0);
      load_table(64'h70, 1'b0, 1'b0);
      n_cmp++; if (done_seen != 0) begin n_fail++; $display("FAIL par_bad_done: got %0d expected 0", done_seen); end
      n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_err: got %b expected 1", cfg_err); end
      eval_all(8'h96, "par_bad");
      load_table(64'h70, 1'b1, 1'b0);
      n_cmp++; if (done_seen != 1) begin n_fail++; $display("FAIL par_good_done: got %0d expected 1", done_seen); end
      n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL par_good_err: got %b expected 0", cfg_err); end
      eval_all(8'h70, "par_good");
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int n = 0; n < 100 && m_busy; n++)
         cycle(0, 0, 1, 0, 1, 1'($urandom_range(0, 1)));
      repeat (3) cycle(0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 0; in_vec = 0; out_ready = 0;
      cfg_start = 0; cfg_bit_valid = 0; cfg_bit = 0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_default_table();
      test_backpressure();
      test_load_96();
      test_reset_mid_load();
      test_start_priority();
`ifdef LUT_EVAL_SEQ_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lut_eval_seq.md
LUT_EVAL_SEQ -- requirements
Module: lut_eval_seq

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of truth-table inputs (legal range 1..6).
REQ-002 SHALL have parameter TT_INIT, default 64'h70, reset truth table (low 2^N_IN bits used).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start  input  1  begin serial truth-table load.
REQ-006 SHALL have port cfg_bit_valid  input  1  cfg_bit qualifier.
REQ-007 SHALL have port cfg_bit  input  1  serial table bit, MSB first.
REQ-008 SHALL have port cfg_busy  output  1  load in progress.
REQ-009 SHALL have port cfg_done  output  1  one-cycle pulse, new table committed.
REQ-010 SHALL have port cfg_err  output  1  parity failure flag.
REQ-011 SHALL have port in_valid  input  1  input vector offered.
REQ-012 SHALL have port in_ready  output  1  input vector accepted when in_valid&in_ready.
REQ-013 SHALL have port in_vec  input  N_IN  input vector; in_vec[N_IN-1] is the MSB of the row index.
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready.
REQ-016 SHALL have port out_bit  output  1  evaluated result.

Function
REQ-017 SHALL compute result = TT[2^N_IN-1-idx], idx = in_vec; TT=8'h70 gives 1 for idx 1,2,3, else 0.
REQ-018 SHALL have states RUN and LOAD; RUN->LOAD on cfg_start; LOAD->RUN after the last bit is shifted.
REQ-019 SHALL shift into a shadow register; the live table updates only on the cycle after the final bit, atomically.
REQ-020 SHALL take 2^N_IN bits per load (2^N_IN+1 with parity, REQ-036); cfg_bit_valid=0 cycles stall the count.
REQ-021 SHALL assert cfg_busy throughout LOAD, pulse cfg_done for one cycle on commit.
REQ-022 SHALL restart the bit count on cfg_start during LOAD, discarding shadow contents.
REQ-023 SHALL drive in_ready = (state==RUN) & (count<2) & !cfg_start.
REQ-024 SHALL buffer results in a 2-entry FIFO; accepted input in cycle t gives out_valid in cycle t+1 if FIFO was empty.
REQ-025 SHALL sustain one result per cycle when out_ready is held high.
REQ-026 SHALL allow simultaneous push and pop with count=2 unchanged only if in_ready was high (count<2 required to push).
REQ-027 SHALL keep results already queued unchanged across a table reload (evaluated with the table live at acceptance).
REQ-028 SHALL hold out_bit and out_valid stable while out_valid&!out_ready.
REQ-029 SHALL give cfg_start priority over in_valid in the same cycle: input not accepted.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set state=RUN, table=TT_INIT, FIFO empty.
REQ-031 SHALL reset outputs: cfg_busy=0, cfg_done=0, cfg_err=0, out_valid=0, out_bit=0, in_ready=1 after release.
REQ-032 SHALL, on reset mid-load, discard the shadow; table reverts to TT_INIT.
REQ-033 SHALL, on reset with FIFO non-empty, drop all queued results.

Configuration
REQ-034 SHALL use macro LUT_EVAL_SEQ_PARITY_EN.
REQ-035 SHALL, without the macro, load exactly 2^N_IN bits and tie cfg_err to 0.
REQ-036 SHALL, with the macro, load one extra trailing even-parity bit; XOR of all table bits plus parity must be 0.
REQ-037 SHALL, on parity mismatch, keep the old table, suppress cfg_done, set cfg_err until next cfg_start or reset.

Verification
REQ-038 SHALL check: reset, N_IN=3, in_vec 0..7 with out_ready=1 -> out_bit 0,1,1,1,0,0,0,0, each one cycle after acceptance.
REQ-039 SHALL check: load 8'h96 MSB first with gaps in cfg_bit_valid -> cfg_done once, then in_vec 0..7 yields 1,0,0,1,0,1,1,0.
REQ-040 SHALL check: out_ready=0, push 3 vectors -> in_ready low after 2 accepted; release -> both results in order, third then accepted.
REQ-041 SHALL check: rst_n low after 4 of 8 cfg bits -> cfg_busy=0, table evaluates as 8'h70.
REQ-042 SHALL check: cfg_start and in_valid same cycle -> input not accepted, cfg_busy=1 next cycle.
REQ-043 SHALL check (macro on): load 8'h70 with parity 0 -> cfg_err=1, no cfg_done, table unchanged; parity 1 -> commit.
